// File: rtl/coeff_load_sequencer.sv
// coeff_load_sequencer: walks coefficient indices, pulsing load_coeff and waiting on modwait per index.
// Optional watchdog on modwait in WAIT enabled by macro COEFF_LOAD_TIMEOUT_EN.
module coeff_load_sequencer #(
    parameter int NUM_COEFFS      = 4,
    parameter int COEFF_NUM_WIDTH = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       new_coefficient_set,
    input  logic                       modwait,
    output logic                       load_coeff,
    output logic [COEFF_NUM_WIDTH-1:0] coefficient_num,
    output logic                       coeff_set_clear,
    output logic                       load_busy,
    output logic                       load_err
);
    typedef enum logic [2:0] {IDLE, LOAD, GUARD, WAIT, CLEAR} state_t;

    localparam logic [COEFF_NUM_WIDTH-1:0] LAST = COEFF_NUM_WIDTH'(NUM_COEFFS - 1);

    state_t                     state_q, state_d;
    logic [COEFF_NUM_WIDTH-1:0] idx_q, idx_d;
    logic                       timeout;

`ifdef COEFF_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout  = state_q == WAIT && modwait && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    assign load_err = err_q;

    // Watchdog: count busy WAIT cycles; error is sticky until the next sequence starts
    always_comb begin
        cnt_d = (state_q == WAIT && state_d == WAIT) ? cnt_q + 1'b1 : '0;
        err_d = timeout ? 1'b1 : (state_q == IDLE && state_d == LOAD) ? 1'b0 : err_q;
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout  = 1'b0;
    assign load_err = 1'b0;
`endif

    // Next-state and index logic; a cancel or timeout drops back to IDLE without a clear pulse
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (new_coefficient_set && !modwait) state_d = LOAD;
            end
            LOAD:  state_d = GUARD;
            GUARD: state_d = WAIT;
            WAIT: begin
                if (timeout) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (!modwait) begin
                    if (!new_coefficient_set) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else if (idx_q == LAST) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = LOAD;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State and index registers
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign load_coeff      = state_q == LOAD;
    assign coeff_set_clear = state_q == CLEAR;
    assign load_busy       = state_q != IDLE;
    assign coefficient_num = idx_q;
endmodule

// File: tb/tb_coeff_load_sequencer.sv
// tb_coeff_load_sequencer: directed self-checking bench for coeff_load_sequencer.
module tb_coeff_load_sequencer;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       new_coefficient_set = 1'b0;
    logic       modwait = 1'b0;
    logic       load_coeff;
    logic [1:0] coefficient_num;
    logic       coeff_set_clear;
    logic       load_busy;
    logic       load_err;
    int         n_checks = 0;
    int         n_fails = 0;

    always #5 clk = ~clk;

    coeff_load_sequencer #(
        .NUM_COEFFS(4),
        .COEFF_NUM_WIDTH(2),
`ifdef COEFF_LOAD_TIMEOUT_EN
        .TIMEOUT_CYCLES(8)
`else
        .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .new_coefficient_set(new_coefficient_set),
        .modwait(modwait),
        .load_coeff(load_coeff),
        .coefficient_num(coefficient_num),
        .coeff_set_clear(coeff_set_clear),
        .load_busy(load_busy),
        .load_err(load_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the packed outputs {load_coeff, coefficient_num, coeff_set_clear, load_busy, load_err}
    task automatic chk_all(input string tag, input logic lc, input logic [1:0] num, input logic clr, input logic busy, input logic err);
        chk(tag, {27'd0, load_coeff, coefficient_num, coeff_set_clear, load_busy, load_err},
                 {27'd0, lc, num, clr, busy, err});
    endtask

    // Entered with the DUT in LOAD for index idx; controller raises modwait during GUARD and holds it 3 cycles.
    // Returns one cycle after modwait falls.
    task automatic handshake(input logic [1:0] idx);
        chk_all($sformatf("load_idx%0d", idx), 1'b1, idx, 1'b0, 1'b1, 1'b0);
        tick();
        modwait = 1'b1;
        chk_all($sformatf("guard_idx%0d", idx), 1'b0, idx, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        modwait = 1'b0;
        chk_all($sformatf("wait_idx%0d", idx), 1'b0, idx, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        // Reset while inputs are active
        n_rst = 1'b0;
        new_coefficient_set = 1'b1;
        modwait = 1'b1;
        tick();
        chk_all("reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        new_coefficient_set = 1'b0;
        modwait = 1'b0;
        tick();
        chk_all("idle_after_reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Full load with one-cycle start latency
        new_coefficient_set = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) handshake(2'(i));
        chk_all("clear_pulse", 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);

        // Re-trigger: set still high after CLEAR starts a new sequence from index 0
        tick();
        chk_all("retrigger_idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        handshake(2'd0);
        handshake(2'd1);
        chk_all("load_idx2_pre_reset", 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);

        // Reset during the idx=2 GUARD
        tick();
        modwait = 1'b1;
        chk("guard_idx2_num", {30'd0, coefficient_num}, 32'd2);
        n_rst = 1'b0;
        tick();
        chk_all("reset_mid_seq", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        modwait = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) handshake(2'(i));
        chk_all("clear_after_restart", 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
        new_coefficient_set = 1'b0;
        tick();
        chk_all("idle_after_clear", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Start gating: request held off while modwait is high
        new_coefficient_set = 1'b1;
        modwait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all($sformatf("gated_%0d", i), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        end
        modwait = 1'b0;
        tick();
        handshake(2'd0);

        // Cancel during the idx=1 WAIT: handshake completes, no clear pulse
        chk_all("load_idx1_cancel", 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        tick();
        modwait = 1'b1;
        tick();
        new_coefficient_set = 1'b0;
        tick();
        chk_all("cancel_still_wait", 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        modwait = 1'b0;
        tick();
        chk_all("cancel_idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("cancel_no_clear", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

`ifdef COEFF_LOAD_TIMEOUT_EN
        // Watchdog: modwait stuck high after the first load
        new_coefficient_set = 1'b1;
        tick();
        chk_all("to_load", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        modwait = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk_all("to_wait7", 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("to_err", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("to_err_sticky", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        modwait = 1'b0;
        tick();
        chk_all("to_err_cleared", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/coeff_load_sequencer.md
Name: coeff_load_sequencer

Overview:
- Sits directly downstream of ahb_lite_slave, between the slave's coefficient registers and the FIR filter controller.
- When software sets the coefficient-set confirmation bit (new_coefficient_set), the block walks coefficient_num from 0 up to NUM_COEFFS-1.
- For each index it pulses load_coeff and waits for the FIR controller to finish (modwait low) before advancing.
- When all coefficients are loaded, it issues a one-cycle clear pulse so the slave can drop its confirmation bit.

Parameters:
NUM_COEFFS, 4, number of coefficients loaded per set (F0..F3)
COEFF_NUM_WIDTH, 2, width of coefficient_num; must satisfy 2**COEFF_NUM_WIDTH >= NUM_COEFFS
TIMEOUT_CYCLES, 64, watchdog limit on modwait high in WAIT (only with COEFF_LOAD_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  reset, synchronous, active-low
new_coefficient_set  input  1  level from slave: coefficient set confirmed by host
modwait  input  1  level from FIR controller: busy
load_coeff  output  1  one-cycle pulse: FIR controller loads the currently selected coefficient
coefficient_num  output  COEFF_NUM_WIDTH  index selecting fir_coefficient mux in slave
coeff_set_clear  output  1  one-cycle pulse: slave clears new_coefficient_set
load_busy  output  1  high from LOAD through CLEAR inclusive
load_err  output  1  sticky watchdog error (tied 0 without macro)

Behaviour:
- One clock (clk); reset n_rst is synchronous and active-low. All state updates on rising clk only.
- Reset: state=IDLE, coefficient_num=0, load_coeff=0, coeff_set_clear=0, load_busy=0, load_err=0.
- Outputs are Moore-decoded from registered state/index; no combinational input-to-output paths.
- States and transitions:
  - IDLE: if new_coefficient_set=1 and modwait=0, go to LOAD with idx=0; otherwise stay in IDLE.
  - LOAD: load_coeff=1 for exactly one cycle, then go to GUARD.
  - GUARD: one dead cycle so the controller can raise modwait, then go to WAIT.
  - WAIT: when modwait=0, go to CLEAR if idx=NUM_COEFFS-1; otherwise idx+1 and go to LOAD.
  - CLEAR: coeff_set_clear=1 for one cycle, idx returns to 0, go to IDLE.
- Timing:
  - Latency from new_coefficient_set sampled high in IDLE to first load_coeff is 1 cycle.
  - coefficient_num is stable from LOAD through the end of that index's WAIT.
  - In IDLE, coefficient_num=0.
- Start gating: a start request while modwait=1 is held off; no load_coeff until modwait=0.
- Cancel: if new_coefficient_set is sampled 0 in WAIT with modwait=0, return to IDLE with idx=0 and no coeff_set_clear.
  - A cancelled coefficient still completes its own handshake first.
- Re-trigger: if new_coefficient_set is still 1 in the cycle after CLEAR, a new sequence starts from idx 0.
  - This is legal: the slave clears with one cycle of lag.
- Index arithmetic is unsigned COEFF_NUM_WIDTH-bit; idx never exceeds NUM_COEFFS-1 (no wrap).
- A reset in any state returns everything to reset values on the next edge; no partial pulses complete.

Optional Feature:
COEFF_LOAD_TIMEOUT_EN
- Defined:
  - Counter increments each WAIT cycle with modwait=1 and clears on leaving WAIT.
  - On reaching TIMEOUT_CYCLES it sets load_err (sticky) and goes to IDLE with no coeff_set_clear.
  - load_err clears on the next entry into LOAD with idx=0, or on reset.
- Not defined: no counter; load_err tied to 0; WAIT waits indefinitely.

Test Plan:
- Reset with new_coefficient_set=1, modwait=1 -> all outputs 0; coefficient_num=0 on the first cycle after reset.
- Full load: set new_coefficient_set=1; controller model raises modwait 1 cycle after each load_coeff and holds it 3 cycles -> exactly 4 load_coeff pulses with coefficient_num=0,1,2,3; one coeff_set_clear 1 cycle after the 4th modwait fall; load_busy high throughout.
- Start gating: new_coefficient_set=1 while modwait=1 for 5 cycles -> no load_coeff until the cycle after modwait drops; then normal sequence from idx 0.
- Cancel: drop new_coefficient_set during the idx=1 WAIT -> idx=1 handshake completes; return to IDLE; no coeff_set_clear; coefficient_num=0.
- Reset mid-sequence: assert n_rst=0 during the idx=2 GUARD -> next edge: IDLE, all outputs 0; with set still 1 after release, restart at idx 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): hold modwait=1 after the first load_coeff -> load_err=1 after 8 WAIT cycles; IDLE; no clear pulse; load_err drops at the next sequence's first load_coeff.
